// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU with registered carry/zero flags,
// and the EX/MEM pipeline register (PR3_*) with stall/flush control.
module ex_stage #(
  parameter int WORD_LEN        = 8,
  parameter int INSTRUCTION_LEN = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [INSTRUCTION_LEN-1:0] PR2_instruction,
  input  logic [WORD_LEN-1:0]        PR2_RF_out1,
  input  logic [WORD_LEN-1:0]        PR2_RF_out2,
  input  logic [2:0]                 PR2_RF_r2,
  input  logic [3:0]                 PR2_ALU_op,
  input  logic                       PR2_sel_ALU_src_reg2,
  input  logic                       PR2_sel_ALU_src_const,
  input  logic                       PR2_sel_ALU_src_shift_count,
  input  logic                       PR2_sel_Cin_alu,
  input  logic                       PR2_MEM_write,
  input  logic                       PR2_MEM_read,
  input  logic                       PR2_sel_RF_write_src_ALU,
  input  logic                       PR2_sel_RF_write_src_MEM,
  input  logic                       PR2_RF_write_en,
  input  logic [WORD_LEN-1:0]        WB_data,
  input  logic [2:0]                 WB_rd,
  input  logic                       WB_write_en,
  output logic [WORD_LEN-1:0]        PR3_ALU_result,
  output logic [WORD_LEN-1:0]        PR3_store_data,
  output logic [2:0]                 PR3_rd,
  output logic                       PR3_MEM_write,
  output logic                       PR3_MEM_read,
  output logic                       PR3_sel_RF_write_src_ALU,
  output logic                       PR3_sel_RF_write_src_MEM,
  output logic                       PR3_RF_write_en,
  output logic                       C_flag,
  output logic                       Z_flag
);

  localparam int W = WORD_LEN;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_ROL  = 4'd7,
    OP_ROR  = 4'd8,
    OP_PASS = 4'd9
  } alu_op_t;

  alu_op_t    op;
  logic [2:0] rd, rs, shamt, amt;
  logic [7:0] imm;
  logic [W-1:0] op_a, fwd2, op_b, result;
  logic [W:0]   wide;
  logic [2*W-1:0] dbl;
  logic         cin, c_next, c_upd, z_upd;
  logic         unused_instr;

  assign op           = alu_op_t'(PR2_ALU_op);
  assign rd           = PR2_instruction[13:11];
  assign rs           = PR2_instruction[10:8];
  assign imm          = PR2_instruction[7:0];
  assign shamt        = PR2_instruction[2:0];
  assign unused_instr = ^PR2_instruction[INSTRUCTION_LEN-1:14];

  // A load in EX/MEM has no data yet, so it must not be forwarded.
  always_comb begin
    if (PR3_RF_write_en && !PR3_MEM_read && PR3_rd == rs)
      op_a = PR3_ALU_result;
    else if (WB_write_en && WB_rd == rs)
      op_a = WB_data;
    else
      op_a = PR2_RF_out1;

    if (PR3_RF_write_en && !PR3_MEM_read && PR3_rd == PR2_RF_r2)
      fwd2 = PR3_ALU_result;
    else if (WB_write_en && WB_rd == PR2_RF_r2)
      fwd2 = WB_data;
    else
      fwd2 = PR2_RF_out2;

    if (PR2_sel_ALU_src_const)
      op_b = W'(imm);
    else if (PR2_sel_ALU_src_shift_count)
      op_b = W'(shamt);
    else if (PR2_sel_ALU_src_reg2)
      op_b = fwd2;
    else
      op_b = '0;
  end

  always_comb begin
    result = '0;
    wide   = '0;
    dbl    = '0;
    c_next = C_flag;
    c_upd  = 1'b0;
    z_upd  = 1'b1;
    amt    = op_b[2:0];
    cin    = PR2_sel_Cin_alu & C_flag;
    case (op)
      OP_ADD: begin
        {c_next, result} = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(cin);
        c_upd = 1'b1;
      end
      OP_SUB: begin
        {c_next, result} = {1'b0, op_a} - {1'b0, op_b} - (W+1)'(cin);
        c_upd = 1'b1;
      end
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      // Extra bit beside the word catches the last bit shifted out.
      OP_SHL: begin
        wide   = {1'b0, op_a} << amt;
        result = wide[W-1:0];
        c_next = wide[W];
        c_upd  = (amt != 3'd0);
      end
      OP_SHR: begin
        wide   = {op_a, 1'b0} >> amt;
        result = wide[W:1];
        c_next = wide[0];
        c_upd  = (amt != 3'd0);
      end
      OP_ROL: begin
        dbl    = {op_a, op_a} << amt;
        result = dbl[2*W-1:W];
      end
      OP_ROR: begin
        dbl    = {op_a, op_a} >> amt;
        result = dbl[W-1:0];
      end
      OP_PASS: result = op_b;
      default: begin
        result = '0;
        z_upd  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      PR3_ALU_result           <= '0;
      PR3_store_data           <= '0;
      PR3_rd                   <= '0;
      PR3_MEM_write            <= 1'b0;
      PR3_MEM_read             <= 1'b0;
      PR3_sel_RF_write_src_ALU <= 1'b0;
      PR3_sel_RF_write_src_MEM <= 1'b0;
      PR3_RF_write_en          <= 1'b0;
      C_flag                   <= 1'b0;
      Z_flag                   <= 1'b0;
    end else if (flush) begin
      PR3_ALU_result           <= '0;
      PR3_store_data           <= '0;
      PR3_rd                   <= '0;
      PR3_MEM_write            <= 1'b0;
      PR3_MEM_read             <= 1'b0;
      PR3_sel_RF_write_src_ALU <= 1'b0;
      PR3_sel_RF_write_src_MEM <= 1'b0;
      PR3_RF_write_en          <= 1'b0;
    end else if (!stall) begin
      PR3_ALU_result           <= result;
      PR3_store_data           <= fwd2;
      PR3_rd                   <= rd;
      PR3_MEM_write            <= PR2_MEM_write;
      PR3_MEM_read             <= PR2_MEM_read;
      PR3_sel_RF_write_src_ALU <= PR2_sel_RF_write_src_ALU;
      PR3_sel_RF_write_src_MEM <= PR2_sel_RF_write_src_MEM;
      PR3_RF_write_en          <= PR2_RF_write_en;
      if (PR2_RF_write_en) begin
        if (c_upd) C_flag <= c_next;
        if (z_upd) Z_flag <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: the driver queues hand-computed
// expectations; a monitor compares them one cycle after each rising edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [18:0] instr;
  logic [7:0]  rf1, rf2, wb_data;
  logic [2:0]  r2, wb_rd;
  logic [3:0]  alu_op;
  logic        s_reg2, s_const, s_shift, s_cin;
  logic [4:0]  ctl;
  logic        wb_we;

  logic [7:0]  res, sd;
  logic [2:0]  prd;
  logic        m_wr, m_rd, s_alu, s_mem, we, c_flag, z_flag;

  typedef struct {
    logic [7:0] res;
    logic [7:0] sd;
    logic [2:0] rd;
    logic [4:0] ctl;
    logic       c;
    logic       z;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage #(.WORD_LEN(8), .INSTRUCTION_LEN(19)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .PR2_instruction(instr), .PR2_RF_out1(rf1), .PR2_RF_out2(rf2),
    .PR2_RF_r2(r2), .PR2_ALU_op(alu_op),
    .PR2_sel_ALU_src_reg2(s_reg2), .PR2_sel_ALU_src_const(s_const),
    .PR2_sel_ALU_src_shift_count(s_shift), .PR2_sel_Cin_alu(s_cin),
    .PR2_MEM_write(ctl[4]), .PR2_MEM_read(ctl[3]),
    .PR2_sel_RF_write_src_ALU(ctl[2]), .PR2_sel_RF_write_src_MEM(ctl[1]),
    .PR2_RF_write_en(ctl[0]),
    .WB_data(wb_data), .WB_rd(wb_rd), .WB_write_en(wb_we),
    .PR3_ALU_result(res), .PR3_store_data(sd), .PR3_rd(prd),
    .PR3_MEM_write(m_wr), .PR3_MEM_read(m_rd),
    .PR3_sel_RF_write_src_ALU(s_alu), .PR3_sel_RF_write_src_MEM(s_mem),
    .PR3_RF_write_en(we), .C_flag(c_flag), .Z_flag(z_flag)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("alu_result", res, e.res);
      chk("store_data", sd, e.sd);
      chk("rd", {5'b0, prd}, {5'b0, e.rd});
      chk("ctl", {3'b0, m_wr, m_rd, s_alu, s_mem, we}, {3'b0, e.ctl});
      chk("flags_cz", {6'b0, c_flag, z_flag}, {6'b0, e.c, e.z});
    end
  end

  task automatic idle();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    instr = '0; rf1 = '0; rf2 = '0; r2 = '0; alu_op = '0;
    s_reg2 = 1'b0; s_const = 1'b0; s_shift = 1'b0; s_cin = 1'b0;
    ctl = '0; wb_data = '0; wb_rd = '0; wb_we = 1'b0;
  endtask

  // bsel: 0 none, 1 const, 2 shift count, 3 reg2
  task automatic setop(input logic [2:0] d, input logic [2:0] s, input logic [7:0] im,
                       input logic [7:0] a, input logic [3:0] op, input int unsigned bsel,
                       input logic ci, input logic [4:0] c);
    instr   = {5'b0, d, s, im};
    rf1     = a;
    alu_op  = op;
    s_const = (bsel == 1);
    s_shift = (bsel == 2);
    s_reg2  = (bsel == 3);
    s_cin   = ci;
    ctl     = c;
  endtask

  task automatic go(input logic [7:0] er, input logic [7:0] es, input logic [2:0] ed,
                    input logic [4:0] ec, input logic c, input logic z);
    exp_t e;
    e.res = er; e.sd = es; e.rd = ed; e.ctl = ec; e.c = c; e.z = z;
    q.push_back(e);
    @(negedge clk);
  endtask

  localparam logic [4:0] ALU_WR = 5'b00101;
  localparam logic [4:0] LOAD   = 5'b01011;
  localparam logic [4:0] STORE  = 5'b10000;

  initial begin
    // Reset with busy inputs
    idle(); rst = 1'b0; setop(3'd7, 3'd1, 8'hFF, 8'hAA, 4'd0, 1, 1'b1, 5'b11111);
    wb_we = 1'b1; wb_rd = 3'd1; wb_data = 8'h55;
    go(8'h00, 8'h00, 3'd0, 5'b00000, 1'b0, 1'b0);
    // ADD with carry out, then ADC
    idle(); setop(3'd1, 3'd0, 8'h20, 8'hF0, 4'd0, 1, 1'b0, ALU_WR);
    go(8'h10, 8'h00, 3'd1, ALU_WR, 1'b1, 1'b0);
    idle(); setop(3'd2, 3'd3, 8'h01, 8'h01, 4'd0, 1, 1'b1, ALU_WR);
    go(8'h03, 8'h00, 3'd2, ALU_WR, 1'b0, 1'b0);
    // Back-to-back dependency through EX/MEM
    idle(); setop(3'd3, 3'd0, 8'h00, 8'h05, 4'd0, 1, 1'b0, ALU_WR);
    go(8'h05, 8'h00, 3'd3, ALU_WR, 1'b0, 1'b0);
    idle(); setop(3'd4, 3'd3, 8'h01, 8'h00, 4'd0, 1, 1'b0, ALU_WR);
    go(8'h06, 8'h00, 3'd4, ALU_WR, 1'b0, 1'b0);
    // EX/MEM beats MEM/WB on both operands
    idle(); setop(3'd3, 3'd0, 8'h00, 8'h05, 4'd0, 1, 1'b0, ALU_WR);
    go(8'h05, 8'h00, 3'd3, ALU_WR, 1'b0, 1'b0);
    idle(); setop(3'd4, 3'd3, 8'h01, 8'h00, 4'd0, 1, 1'b0, ALU_WR);
    r2 = 3'd3; wb_we = 1'b1; wb_rd = 3'd3; wb_data = 8'h77;
    go(8'h06, 8'h05, 3'd4, ALU_WR, 1'b0, 1'b0);
    // Load in EX/MEM is not forwarded; MEM/WB supplies the value
    idle(); setop(3'd2, 3'd0, 8'h04, 8'h10, 4'd0, 1, 1'b0, LOAD);
    go(8'h14, 8'h00, 3'd2, LOAD, 1'b0, 1'b0);
    idle(); setop(3'd5, 3'd2, 8'h00, 8'h99, 4'd0, 0, 1'b0, ALU_WR);
    r2 = 3'd2; rf2 = 8'h11; wb_we = 1'b1; wb_rd = 3'd2; wb_data = 8'h40;
    go(8'h40, 8'h40, 3'd5, ALU_WR, 1'b0, 1'b0);
    // Shifts and rotates
    idle(); setop(3'd1, 3'd0, 8'h01, 8'h81, 4'd5, 2, 1'b0, ALU_WR);
    go(8'h02, 8'h00, 3'd1, ALU_WR, 1'b1, 1'b0);
    idle(); setop(3'd2, 3'd0, 8'h01, 8'h01, 4'd8, 2, 1'b0, ALU_WR);
    go(8'h80, 8'h00, 3'd2, ALU_WR, 1'b1, 1'b0);
    idle(); setop(3'd3, 3'd0, 8'h00, 8'h5A, 4'd6, 2, 1'b0, ALU_WR);
    go(8'h5A, 8'h00, 3'd3, ALU_WR, 1'b1, 1'b0);
    idle(); setop(3'd4, 3'd0, 8'h03, 8'h10, 4'd6, 2, 1'b0, ALU_WR);
    go(8'h02, 8'h00, 3'd4, ALU_WR, 1'b0, 1'b0);
    idle(); setop(3'd5, 3'd0, 8'h00, 8'h81, 4'd7, 3, 1'b0, ALU_WR);
    r2 = 3'd7; rf2 = 8'h01;
    go(8'h03, 8'h01, 3'd5, ALU_WR, 1'b0, 1'b0);
    // Zero result sets Z
    idle(); setop(3'd6, 3'd0, 8'h3C, 8'h3C, 4'd4, 1, 1'b0, ALU_WR);
    go(8'h00, 8'h00, 3'd6, ALU_WR, 1'b0, 1'b1);
    // Stall holds everything, flush+stall bubbles PR3 but keeps flags
    for (int i = 0; i < 2; i++) begin
      idle(); stall = 1'b1; setop(3'd7, 3'd0, 8'h0F, 8'hFF, 4'd2, 1, 1'b0, ALU_WR);
      go(8'h00, 8'h00, 3'd6, ALU_WR, 1'b0, 1'b1);
    end
    idle(); stall = 1'b1; flush = 1'b1; setop(3'd7, 3'd0, 8'h0F, 8'hFF, 4'd2, 1, 1'b0, ALU_WR);
    go(8'h00, 8'h00, 3'd0, 5'b00000, 1'b0, 1'b1);
    // Flags only move when the instruction writes the RF
    idle(); setop(3'd2, 3'd0, 8'h00, 8'h01, 4'd0, 1, 1'b0, ALU_WR);
    go(8'h01, 8'h00, 3'd2, ALU_WR, 1'b0, 1'b0);
    idle(); setop(3'd1, 3'd0, 8'h05, 8'h05, 4'd1, 1, 1'b0, 5'b00000);
    go(8'h00, 8'h00, 3'd1, 5'b00000, 1'b0, 1'b0);
    idle(); setop(3'd3, 3'd0, 8'h06, 8'h05, 4'd1, 1, 1'b0, ALU_WR);
    go(8'hFF, 8'h00, 3'd3, ALU_WR, 1'b1, 1'b0);
    idle(); setop(3'd4, 3'd0, 8'h01, 8'h10, 4'd1, 1, 1'b1, ALU_WR);
    go(8'h0E, 8'h00, 3'd4, ALU_WR, 1'b0, 1'b0);
    // Flush alone
    idle(); flush = 1'b1; setop(3'd5, 3'd0, 8'h01, 8'h80, 4'd0, 1, 1'b0, ALU_WR);
    go(8'h00, 8'h00, 3'd0, 5'b00000, 1'b0, 1'b0);
    // Unassigned opcode: result 0, Z untouched
    idle(); setop(3'd5, 3'd0, 8'h00, 8'h33, 4'd12, 1, 1'b0, ALU_WR);
    go(8'h00, 8'h00, 3'd5, ALU_WR, 1'b0, 1'b0);
    // Wraparound sets C and Z, then mid-stream reset overrides stall/flush
    idle(); setop(3'd6, 3'd0, 8'h80, 8'h80, 4'd0, 1, 1'b0, ALU_WR);
    go(8'h00, 8'h00, 3'd6, ALU_WR, 1'b1, 1'b1);
    idle(); rst = 1'b0; stall = 1'b1; flush = 1'b1;
    setop(3'd7, 3'd0, 8'h01, 8'h22, 4'd0, 1, 1'b0, ALU_WR);
    go(8'h00, 8'h00, 3'd0, 5'b00000, 1'b0, 1'b0);
    // PASS, then store picks up forwarded operand 2
    idle(); setop(3'd7, 3'd0, 8'hA5, 8'h00, 4'd9, 1, 1'b0, ALU_WR);
    go(8'hA5, 8'h00, 3'd7, ALU_WR, 1'b0, 1'b0);
    idle(); setop(3'd0, 3'd0, 8'h03, 8'h20, 4'd0, 1, 1'b0, STORE);
    r2 = 3'd7; rf2 = 8'h00;
    go(8'h23, 8'hA5, 3'd0, STORE, 1'b0, 1'b0);

    idle();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 8-bit pipelined core, sitting directly downstream of the ID/EX pipeline register. It consumes that register's outputs and forwards operands from EX/MEM and MEM/WB. It runs the ALU with registered carry and zero flags, then captures result, store data, destination and control into the EX/MEM register (PR3_*). Operation is single-cycle, with stall (hold) and flush (bubble) controls from the hazard unit.

## Interface
Parameters:
- WORD_LEN, 8, data width
- INSTRUCTION_LEN, 19, instruction width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  hold PR3_* and flags
- flush  in  1  load bubble into PR3_*
- PR2_instruction  in  INSTRUCTION_LEN  fields: rd=[13:11], rs=[10:8], imm=[7:0], shamt=[2:0]
- PR2_RF_out1, PR2_RF_out2  in  WORD_LEN  register operands
- PR2_RF_r2  in  3  index of operand 2
- PR2_ALU_op  in  4  ALU operation
- PR2_sel_ALU_src_reg2, PR2_sel_ALU_src_const, PR2_sel_ALU_src_shift_count, PR2_sel_Cin_alu  in  1 each  operand/carry selects
- PR2_MEM_write, PR2_MEM_read, PR2_sel_RF_write_src_ALU, PR2_sel_RF_write_src_MEM, PR2_RF_write_en  in  1 each  downstream controls
- WB_data  in  WORD_LEN  MEM/WB writeback value
- WB_rd  in  3  MEM/WB destination
- WB_write_en  in  1  MEM/WB writes RF
- PR3_ALU_result  out  WORD_LEN  registered ALU result
- PR3_store_data  out  WORD_LEN  registered forwarded operand 2
- PR3_rd  out  3  registered destination
- PR3_MEM_write, PR3_MEM_read, PR3_sel_RF_write_src_ALU, PR3_sel_RF_write_src_MEM, PR3_RF_write_en  out  1 each  registered controls
- C_flag, Z_flag  out  1 each  architectural flags

## Operation
- Forwarding, operand 1 (index rs):
  - EX/MEM wins if PR3_RF_write_en & !PR3_MEM_read & PR3_rd==rs; value is PR3_ALU_result.
  - Otherwise MEM/WB if WB_write_en & WB_rd==rs; value is WB_data.
  - Otherwise PR2_RF_out1.
- Forwarding, operand 2: same rules using PR2_RF_r2 as the index.
- B operand select, priority order:
  - sel_const: imm[7:0]
  - sel_shift_count: {5'b0, shamt}
  - sel_reg2: forwarded operand 2
  - else 0
- ALU ops, A=fwd op1:
  - 0 ADD: A+B+(Cin ? C : 0), C=carry-out
  - 1 SUB: A-B-(Cin ? C : 0), C=borrow
  - 2 AND, 3 OR, 4 XOR
  - 5 SHL by B[2:0], C=last bit out
  - 6 SHR by B[2:0], C=last bit out
  - 7 ROL, 8 ROR by B[2:0]
  - 9 PASS: result=B
  - 10-15: result 0
- Shift by 0: C unchanged.
- Flag update:
  - Z := (result==0) for ops 0-9.
  - C updated only by ops 0, 1, 5, 6.
  - Flags update only when PR2_RF_write_en=1 and not stall/flush.
- Arithmetic is modulo 2^WORD_LEN.
- PR3_store_data = forwarded operand 2; a store writes the latest value.
- Load-use hazards are not detected here; the hazard unit inserts the stall.

## Timing
- Latency 1 cycle: PR2 inputs at edge N appear on PR3_* after edge N.
- Priority per edge: !rst > flush > stall > normal load.
- Reset: every PR3_* output = 0, C_flag = 0, Z_flag = 0.
- flush: all PR3_* = 0; flags held.
- stall: PR3_* and flags held.
- Forwarding uses pre-edge PR3_* values, i.e. the instruction one ahead.
- Simultaneous EX/MEM and MEM/WB match on the same index: EX/MEM wins.
- EX/MEM match on a load (PR3_MEM_read=1): not forwarded; MEM/WB or RF value used.
- rst low for one edge mid-stream clears all state regardless of stall/flush.

## Test plan
- Reset: rst=0 one edge with arbitrary inputs -> all PR3_*, C_flag, Z_flag = 0.
- ADD then ADC: ADD 0xF0+0x20 -> PR3_ALU_result=0x10, C=1, Z=0; next ADD sel_Cin 0x01+0x01 -> 0x03, C=0.
- Back-to-back dependency: instr1 writes r3=0x05; instr2 reads rs=r3 with RF_out1=0x00, B=imm 0x01, op ADD -> result 0x06. Same with WB_rd=3, WB_data=0x77 also asserted -> still 0x06.
- Load not forwarded: PR3_MEM_read=1, PR3_rd=2; next instr rs=r2, WB_rd=2, WB_data=0x40, op PASS of op1 via A+0 -> 0x40.
- Shifts: SHL 0x81 by shamt 1 -> 0x02, C=1. ROR 0x01 by 1 -> 0x80, C held. SHR by 0 -> value unchanged, C held.
- Stall/flush: stall=1 for 2 cycles -> PR3_* and flags frozen. flush=1 together with stall=1 -> PR3_* = 0, flags held. SUB 0x05-0x05 with RF_write_en=0 -> Z unchanged.
